lsu_align_ctrl: RTL and testbench
=================================

// Module: lsu_align_ctrl
// PURPOSE
// - Parametrised load/store alignment controller between the core's memory stage and the data-memory bus.
// - Generates byte enables, lane-shifts store data, and extracts + sign/zero-extends load data for B/H/W/(D).
// - Sequences bus beats; word-boundary-crossing accesses optionally split into two beats.
// PARAMETERS
// - XLEN   32   data/address width; legal values 32 or 64
// - BE_W   XLEN/8 (localparam, derived)   bytes per bus word
// PORTS
// - clk           in   1      single clock, all flops rising edge
// - reset         in   1      synchronous, active-high
// - req_valid     in   1      core request valid
// - req_ready     out  1      block can accept a request (1 only in IDLE, 0 while reset asserted)
// - req_we        in   1      1 = store, 0 = load
// - req_funct3    in   3      [1:0] size 00=B 01=H 10=W 11=D; [2]=1 unsigned load
// - req_addr      in   XLEN   byte address
// - req_wdata     in   XLEN   store data, right-justified
// - rsp_valid     out  1      one-cycle completion pulse, no backpressure
// - rsp_rdata     out  XLEN   extended load data (0 for stores/errors)
// - rsp_err       out  1      valid with rsp_valid: illegal size or unsupported misalignment
// - mem_req       out  1      bus beat request; held until mem_gnt
// - mem_gnt       in   1      bus accepts beat this cycle
// - mem_we        out  1      beat is a write
// - mem_addr      out  XLEN   word-aligned beat address (low log2(BE_W) bits 0)
// - mem_be        out  BE_W   byte enables
// - mem_wdata     out  XLEN   lane-aligned write data
// - mem_rvalid    in   1      read data valid, >=1 cycle after gnt of a read beat
// - mem_rdata     in   XLEN   read data
// BEHAVIOUR
// - Reset: state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_err, rsp_rdata all 0.
// - Accept on req_valid & req_ready; request fields registered; req_ready drops next cycle.
// - off = addr[log2(BE_W)-1:0]; nbytes = 1<<size; cross = (off + nbytes > BE_W).
// - Illegal: size D when XLEN=32, or store with funct3[2]=1 -> RESP with rsp_err=1, no bus traffic.
// - FSM: IDLE -> REQ0 -> (load) WAIT0 -> [REQ1 -> WAIT1 if cross] -> RESP -> IDLE.
//   Stores complete a beat on mem_gnt (no WAIT); crossing store goes REQ0 -> REQ1 -> RESP.
// - mem_req stays high in REQx until mem_gnt; all mem_* outputs stable while waiting.
// - Beat0 addr = addr & ~(BE_W-1); beat1 addr = beat0 + BE_W, wraps modulo 2^XLEN.
// - Enables: 2*BE_W-bit mask ((1<<nbytes)-1)<<off; low half -> beat0, high half -> beat1.
// - Store data: {XLEN'0, wdata} << (8*off) over 2*XLEN; low half beat0, high half beat1.
// - Load: {beat1_data, beat0_data} >> (8*off), truncate to nbytes, sign-extend unless funct3[2].
// - Min latency, aligned load, gnt in REQ0, rvalid next cycle: accept T, rsp_valid T+3.
// - mem_rvalid outside WAITx ignored; reset mid-operation -> IDLE next edge, mem_req 0, pending rvalid dropped.
// - In-word unaligned access (e.g. H at off 1, XLEN=32) is single-beat, not an error.
// CONFIGURATION
// - MISALIGN_SPLIT_EN defined: crossing accesses split into two beats as above.
// - Not defined: crossing access -> RESP with rsp_err=1, rsp_rdata=0, no bus beat issued; REQ1/WAIT1 not built.
// STRUCTURE
// - Package lsu_pkg: size enum (SZ_B/SZ_H/SZ_W/SZ_D), lsu_state_e enum, funct3 field-index constants.
// - Sub-module lsu_byte_lane (combinational): off/size/wdata -> 2*BE_W enable mask and 2*XLEN shifted data.
// TESTING
// - XLEN=32, LW addr 0x100, mem_rdata 0xDEADBEEF -> mem_be 1111, rsp_rdata 0xDEADBEEF, rsp_valid at T+3.
// - LB addr 0x103, rdata 0x80xxxxxx -> mem_be 1000, rsp_rdata 0xFFFFFF80; LBU -> 0x00000080.
// - SH addr 0x102, wdata 0x0000ABCD -> mem_be 1100, mem_wdata 0xABCD0000, single beat.
// - SPLIT_EN: LW addr 0x0FE, beat0 0x11223344 @0x0FC, beat1 0x55667788 @0x100 -> rsp_rdata 0x77881122.
// - No SPLIT_EN: SW addr 0x0FF -> no mem_req, rsp_err=1; funct3=011 on XLEN=32 -> rsp_err=1.
// - mem_gnt held low 5 cycles then reset -> mem_req 0 next cycle, IDLE, late mem_rvalid ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store alignment controller: access sizes, FSM states
// and the field positions inside funct3.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_e;

    localparam int F3_SIZE_LSB = 0;
    localparam int F3_SIZE_MSB = 1;
    localparam int F3_UNSIGNED = 2;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane steering: builds the two-word byte-enable mask and the
// two-word shifted store data for an access of a given size at a byte offset.
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int BE_W  = XLEN / 8,
    localparam int OFF_W = $clog2(BE_W)
) (
    input  logic [OFF_W-1:0]  off,
    input  lsu_size_e         size,
    input  logic [XLEN-1:0]   wdata,
    output logic [2*BE_W-1:0] mask,
    output logic [2*XLEN-1:0] sdata
);

    localparam int MW = 2 * BE_W;

    logic [MW-1:0] base;

    // NOTE: every always_comb output gets a default before the case so no latch is inferred.
    always_comb begin
        base = MW'(8'h01);
        case (size)
            SZ_B:    base = MW'(8'h01);
            SZ_H:    base = MW'(8'h03);
            SZ_W:    base = MW'(8'h0F);
            SZ_D:    base = MW'(8'hFF);
            default: base = MW'(8'h01);
        endcase
    end

    assign mask  = base << off;
    assign sdata = {{XLEN{1'b0}}, wdata} << {off, 3'b000};

endmodule

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller between the memory stage and the data bus.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses into two bus beats.
module lsu_align_ctrl
    import lsu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int BE_W = XLEN / 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [BE_W-1:0] mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int OFF_W = $clog2(BE_W);
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    lsu_state_e        state, state_nxt;
    logic              r_we, r_uns, r_err, r_cross;
    lsu_size_e         r_size;
    logic [OFF_W-1:0]  r_off;
    logic [XLEN-1:0]   r_base, r_wdata, r_b0, r_b1;
    logic [2*BE_W-1:0] lane_mask;
    logic [2*XLEN-1:0] lane_data;

    logic       accept, cross_in, illegal_in, go_beat1;
    logic [3:0] end_byte;

    assign req_ready  = (state == ST_IDLE) && !reset;
    assign accept     = req_valid && req_ready;
    assign end_byte   = 4'(req_addr[OFF_W-1:0]) + (4'd1 << req_funct3[F3_SIZE_MSB:F3_SIZE_LSB]);
    assign cross_in   = end_byte > 4'(BE_W);
    assign illegal_in = ((XLEN == 32) && (req_funct3[F3_SIZE_MSB:F3_SIZE_LSB] == SZ_D))
                      || (req_we && req_funct3[F3_UNSIGNED])
                      || (!SPLIT && cross_in);
    assign go_beat1   = SPLIT && r_cross;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: request/data holding registers need no reset; they are always written before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            r_we    <= req_we;
            r_uns   <= req_funct3[F3_UNSIGNED];
            r_size  <= lsu_size_e'(req_funct3[F3_SIZE_MSB:F3_SIZE_LSB]);
            r_off   <= req_addr[OFF_W-1:0];
            r_base  <= {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            r_wdata <= req_wdata;
            r_err   <= illegal_in;
            r_cross <= cross_in;
        end
        if (state == ST_WAIT0 && mem_rvalid) r_b0 <= mem_rdata;
    end

`ifdef MISALIGN_SPLIT_EN
    always_ff @(posedge clk) begin
        if (state == ST_WAIT1 && mem_rvalid) r_b1 <= mem_rdata;
    end
`else
    assign r_b1 = '0;
`endif

    lsu_byte_lane #(.XLEN(XLEN)) u_lane (
        .off   (r_off),
        .size  (r_size),
        .wdata (r_wdata),
        .mask  (lane_mask),
        .sdata (lane_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept)     state_nxt = illegal_in ? ST_RESP : ST_REQ0;
            ST_REQ0:  if (mem_gnt)    state_nxt = r_we ? (go_beat1 ? ST_REQ1 : ST_RESP) : ST_WAIT0;
            ST_WAIT0: if (mem_rvalid) state_nxt = go_beat1 ? ST_REQ1 : ST_RESP;
`ifdef MISALIGN_SPLIT_EN
            ST_REQ1:  if (mem_gnt)    state_nxt = r_we ? ST_RESP : ST_WAIT1;
            ST_WAIT1: if (mem_rvalid) state_nxt = ST_RESP;
`endif
            ST_RESP:                  state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Window the two loaded words down to the addressed bytes, then extend.
    logic [XLEN-1:0]        ld_low, ld_ext;
    logic signed [XLEN-1:0] ld_tmp;
    logic [6:0]             ld_sh;

    always_comb begin
        ld_low = XLEN'({r_b1, r_b0} >> {r_off, 3'b000});
        ld_sh  = 7'(XLEN) - (7'd8 << r_size);
        ld_tmp = ld_low << ld_sh;
        if (r_uns) ld_ext = ld_tmp >> ld_sh;
        else       ld_ext = ld_tmp >>> ld_sh;
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        case (state)
            ST_REQ0: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_base;
                mem_be    = lane_mask[BE_W-1:0];
                mem_wdata = r_we ? lane_data[XLEN-1:0] : '0;
            end
            ST_REQ1: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_base + XLEN'(BE_W);
                mem_be    = lane_mask[2*BE_W-1:BE_W];
                mem_wdata = r_we ? lane_data[2*XLEN-1:XLEN] : '0;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = r_err;
                rsp_rdata = (r_err || r_we) ? '0 : ld_ext;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Directed, table-driven bench for lsu_align_ctrl (XLEN=32); expectations follow
// whether MISALIGN_SPLIT_EN is defined for the build.
module tb_lsu_align_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_cmp  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    lsu_align_ctrl #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          beats;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] wd0;
        logic [31:0] wd1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one request, grant every beat immediately, return read data the next cycle.
    task automatic run_vec(input int idx, input vec_t v, input bit chk_lat);
        int          beats = 0;
        int          cyc   = 0;
        int          lat   = 0;
        bit          done  = 0;
        bit          rd_pend = 0;
        logic        got_err = 1'b0;
        logic [31:0] got_rd  = '0;
        logic [3:0]  g_be[2];
        logic [31:0] g_a[2];
        logic [31:0] g_wd[2];
        logic        g_we[2];
        @(negedge clk);
        check($sformatf("v%0d_ready", idx), req_ready, 1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
            req_valid  = 1'b0;
            mem_rvalid = rd_pend;
            mem_rdata  = rd_pend ? ((beats == 1) ? v.rd0 : v.rd1) : 32'h0;
            rd_pend    = 1'b0;
            mem_gnt    = 1'b0;
            if (mem_req) begin
                if (beats < 2) begin
                    g_be[beats] = mem_be;
                    g_a[beats]  = mem_addr;
                    g_wd[beats] = mem_wdata;
                    g_we[beats] = mem_we;
                end
                beats++;
                mem_gnt = 1'b1;
                rd_pend = !mem_we;
            end
            if (rsp_valid) begin
                done    = 1'b1;
                lat     = cyc;
                got_err = rsp_err;
                got_rd  = rsp_rdata;
            end
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check($sformatf("v%0d_rsp_seen", idx), done, 1);
        check($sformatf("v%0d_beats", idx), beats, v.beats);
        check($sformatf("v%0d_err", idx), got_err, v.err);
        check($sformatf("v%0d_rdata", idx), got_rd, v.rdata);
        if (chk_lat) check($sformatf("v%0d_latency", idx), lat, 3);
        if (beats >= 1 && v.beats >= 1) begin
            check($sformatf("v%0d_be0", idx), g_be[0], v.be0);
            check($sformatf("v%0d_addr0", idx), g_a[0], v.a0);
            check($sformatf("v%0d_wdata0", idx), g_wd[0], v.wd0);
            check($sformatf("v%0d_we0", idx), g_we[0], v.we);
        end
        if (beats >= 2 && v.beats >= 2) begin
            check($sformatf("v%0d_be1", idx), g_be[1], v.be1);
            check($sformatf("v%0d_addr1", idx), g_a[1], v.a1);
            check($sformatf("v%0d_wdata1", idx), g_wd[1], v.wd1);
            check($sformatf("v%0d_we1", idx), g_we[1], v.we);
        end
    endtask

    initial begin
        //                 we  f3      addr          wdata         rd0           rd1           bts err rdata         be0   be1   a0            a1            wd0           wd1
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 32'h0,        1, 1'b0, 32'hDEADBEEF, 4'hF, 4'h0, 32'h0000_0100, 32'h0,        32'h0,        32'h0});
        vecs.push_back('{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80123456, 32'h0,        1, 1'b0, 32'hFFFFFF80, 4'h8, 4'h0, 32'h0000_0100, 32'h0,        32'h0,        32'h0});
        vecs.push_back('{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80123456, 32'h0,        1, 1'b0, 32'h00000080, 4'h8, 4'h0, 32'h0000_0100, 32'h0,        32'h0,        32'h0});
        vecs.push_back('{1'b1, 3'b001, 32'h0000_0102, 32'h0000ABCD, 32'h0,        32'h0,        1, 1'b0, 32'h0,        4'hC, 4'h0, 32'h0000_0100, 32'h0,        32'hABCD0000, 32'h0});
        vecs.push_back('{1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h12F3A456, 32'h0,        1, 1'b0, 32'hFFFFF3A4, 4'h6, 4'h0, 32'h0000_0100, 32'h0,        32'h0,        32'h0});
        vecs.push_back('{1'b0, 3'b101, 32'h0000_0101, 32'h0,        32'h12F3A456, 32'h0,        1, 1'b0, 32'h0000F3A4, 4'h6, 4'h0, 32'h0000_0100, 32'h0,        32'h0,        32'h0});
        vecs.push_back('{1'b1, 3'b000, 32'h0000_0201, 32'hFFFFFF5A, 32'h0,        32'h0,        1, 1'b0, 32'h0,        4'h2, 4'h0, 32'h0000_0200, 32'h0,        32'hFFFF5A00, 32'h0});
        vecs.push_back('{1'b1, 3'b010, 32'h0000_0300, 32'hCAFEF00D, 32'h0,        32'h0,        1, 1'b0, 32'h0,        4'hF, 4'h0, 32'h0000_0300, 32'h0,        32'hCAFEF00D, 32'h0});
        vecs.push_back('{1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        32'h0,        0, 1'b1, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h0});
        vecs.push_back('{1'b1, 3'b110, 32'h0000_0104, 32'h12345678, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h0});
        vecs.push_back('{1'b0, 3'b000, 32'h0000_0003, 32'h0,        32'h7F000000, 32'h0,        1, 1'b0, 32'h0000007F, 4'h8, 4'h0, 32'h0,        32'h0,        32'h0,        32'h0});
        vecs.push_back('{1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'h80011234, 32'h0,        1, 1'b0, 32'hFFFF8001, 4'hC, 4'h0, 32'h0,        32'h0,        32'h0,        32'h0});
`ifdef MISALIGN_SPLIT_EN
        vecs.push_back('{1'b0, 3'b010, 32'h0000_00FE, 32'h0,        32'h11223344, 32'h55667788, 2, 1'b0, 32'h77881122, 4'hC, 4'h3, 32'h0000_00FC, 32'h0000_0100, 32'h0,        32'h0});
        vecs.push_back('{1'b1, 3'b010, 32'h0000_00FF, 32'hAABBCCDD, 32'h0,        32'h0,        2, 1'b0, 32'h0,        4'h8, 4'h7, 32'h0000_00FC, 32'h0000_0100, 32'hDD000000, 32'h00AABBCC});
        vecs.push_back('{1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0,        32'hAB000000, 32'h000000CD, 2, 1'b0, 32'hFFFFCDAB, 4'h8, 4'h1, 32'hFFFF_FFFC, 32'h0,        32'h0,        32'h0});
`else
        vecs.push_back('{1'b1, 3'b010, 32'h0000_00FF, 32'hAABBCCDD, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_00FE, 32'h0,        32'h11223344, 32'h55667788, 0, 1'b1, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h0});
        vecs.push_back('{1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0,        32'hAB000000, 32'h000000CD, 0, 1'b1, 32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h0});
`endif

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_req_ready", req_ready, 1);

        foreach (vecs[i]) run_vec(i, vecs[i], i == 0);

        // Stall the grant for five cycles, then reset in the middle of the beat.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0100;
        mem_gnt    = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            check($sformatf("stall%0d_mem_req", k), mem_req, 1);
            check($sformatf("stall%0d_mem_addr", k), mem_addr, 32'h0000_0100);
            check($sformatf("stall%0d_mem_be", k), mem_be, 4'hF);
            check($sformatf("stall%0d_rsp_valid", k), rsp_valid, 0);
        end
        reset      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555AAAA;
        @(negedge clk);
        check("midrst_mem_req", mem_req, 0);
        check("midrst_req_ready", req_ready, 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("late_rvalid%0d_rsp_valid", k), rsp_valid, 0);
            check($sformatf("late_rvalid%0d_mem_req", k), mem_req, 0);
            check($sformatf("late_rvalid%0d_ready", k), req_ready, 1);
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        run_vec(100, vecs[0], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule
